// File: rtl/seq_multiplier_16bit.sv
// Iterative shift-add unsigned multiplier (16x16 -> 32) for the MULTU path into HI/LO.
// Optional feature: define MULT_ZERO_SKIP_EN to finish zero-operand products in one cycle.
`timescale 1ns/1ps

module seq_multiplier_16bit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CntW = $clog2(WIDTH);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
`ifdef MULT_ZERO_SKIP_EN
  localparam logic [1:0] StZero = 2'd2;
`endif

  logic [1:0]           state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CntW-1:0]      count_q, count_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  // Ripple-carry accumulation stage
  logic [WIDTH-1:0]     add_a, add_b, add_sum;
  logic                 add_cin, add_cout;
  logic [WIDTH:0]       carry;
  logic [2*WIDTH-1:0]   acc_shift;

  always_comb begin
    add_a    = acc_q[2*WIDTH-1:WIDTH];
    add_b    = acc_q[0] ? mcand_q : '0;
    add_cin  = 1'b0;
    carry    = '0;
    add_sum  = '0;
    carry[0] = add_cin;
    for (int i = 0; i < int'(WIDTH); i++) begin
      add_sum[i]   = add_a[i] ^ add_b[i] ^ carry[i];
      carry[i+1]   = (add_a[i] & add_b[i]) | (carry[i] & (add_a[i] ^ add_b[i]));
    end
    add_cout = carry[WIDTH];
  end

  // Carry-out becomes the new MSB so FFFF*FFFF stays exact.
  assign acc_shift = {add_cout, add_sum, acc_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    count_d   = count_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    product_d = product_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          mcand_d = a;
          acc_d   = {{WIDTH{1'b0}}, b};
          count_d = '0;
          busy_d  = 1'b1;
          state_d = StRun;
`ifdef MULT_ZERO_SKIP_EN
          if ((a == '0) || (b == '0)) begin
            state_d = StZero;
          end
`endif
        end
      end
      StRun: begin
        acc_d   = acc_shift;
        count_d = count_q + 1'b1;
        if (count_q == CntW'(WIDTH - 1)) begin
          product_d = acc_shift;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = StIdle;
        end
      end
`ifdef MULT_ZERO_SKIP_EN
      StZero: begin
        product_d = '0;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = StIdle;
      end
`endif
      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      mcand_q   <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier_16bit.sv
// Scoreboard bench for seq_multiplier_16bit: expected products and completion cycles are
// queued at start and compared when done pulses.
`timescale 1ns/1ps

module tb_seq_multiplier_16bit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] a, b;
  logic        busy, done;
  logic [31:0] product;

  seq_multiplier_16bit #(.WIDTH(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] prod;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic done_prev = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int lat(input logic [15:0] x, input logic [15:0] y);
`ifdef MULT_ZERO_SKIP_EN
    if ((x == 16'h0) || (y == 16'h0)) return 1;
`endif
    return 16;
  endfunction

  // Called right after a negedge; returns at the negedge following the start edge.
  task automatic do_start(input logic [15:0] x, input logic [15:0] y, input bit expect_acc,
                          output int e0);
    exp_t e;
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    if (expect_acc) begin
      e.prod = {16'h0, x} * {16'h0, y};
      e.due  = e0 + lat(x, y);
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    check_eq("drain", sb.size(), 0);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (done) begin
      check_eq("busy_at_done", {31'b0, busy}, 32'h0);
      if (sb.size() == 0) begin
        check_eq("spurious_done", {31'b0, done}, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("product", product, e.prod);
        check_eq("done_cycle", cyc, e.due);
      end
    end
    if (done_prev) check_eq("done_width", {31'b0, done}, 32'h0);
    done_prev = done;
  end

  initial begin
    int e0;
    logic [15:0] rx, ry;
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", {31'b0, busy}, 32'h0);
    check_eq("rst_done", {31'b0, done}, 32'h0);
    check_eq("rst_product", product, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // 3*5: busy across the run, done at E16
    do_start(16'd3, 16'd5, 1'b1, e0);
    check_eq("busy_e0", {31'b0, busy}, 32'h1);
    wait_cyc(e0 + 15);
    check_eq("busy_e15", {31'b0, busy}, 32'h1);
    wait_drain(40);
    check_eq("busy_after", {31'b0, busy}, 32'h0);

    // carry retention and a power-of-two case
    do_start(16'hFFFF, 16'hFFFF, 1'b1, e0);
    wait_drain(40);
    check_eq("hold_ffff", product, 32'hFFFE0001);
    do_start(16'h8000, 16'h0002, 1'b1, e0);
    wait_drain(40);

    // start while busy is ignored
    do_start(16'd7, 16'd9, 1'b1, e0);
    wait_cyc(e0 + 4);
    do_start(16'd2, 16'd2, 1'b0, e0);
    wait_drain(40);
    repeat (20) @(negedge clk);
    check_eq("hold_63", product, 32'd63);

    // reset at E8 aborts with no done
    do_start(16'd100, 16'd200, 1'b1, e0);
    wait_cyc(e0 + 7);
    reset = 1'b1;
    @(negedge clk);
    check_eq("abort_busy", {31'b0, busy}, 32'h0);
    check_eq("abort_done", {31'b0, done}, 32'h0);
    check_eq("abort_product", product, 32'h0);
    sb.delete();
    reset = 1'b0;
    repeat (20) @(negedge clk);
    do_start(16'd2, 16'd3, 1'b1, e0);
    wait_drain(40);

    // back-to-back: start accepted on the cycle done is high
    do_start(16'd4, 16'd4, 1'b1, e0);
    wait_cyc(e0 + 16);
    do_start(16'd10, 16'd10, 1'b1, e0);
    wait_cyc(e0 + 8);
    check_eq("hold_16_mid", product, 32'd16);
    wait_cyc(e0 + 15);
    check_eq("hold_16_late", product, 32'd16);
    wait_drain(40);

    // zero operand
    do_start(16'd0, 16'd1234, 1'b1, e0);
    wait_drain(40);

    for (int i = 0; i < 4; i++) begin
      rx = 16'($urandom_range(0, 65535));
      ry = 16'($urandom_range(0, 65535));
      do_start(rx, ry, 1'b1, e0);
      wait_drain(40);
    end

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
